// File: rtl/multdiv_ctrl.sv
// E-stage multiply/divide sequencer owning HI/LO. Result commits MULT_CYCLES/DIV_CYCLES after accept.
// No backpressure: busy is exported so the hazard unit holds later md ops and MFHI/MFLO.
module multdiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] multdiv_res_E
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  logic               accept;
  logic               rt_zero;
  logic signed [63:0] rs_sx, rt_sx;
  logic [63:0]        prod_s, prod_u;
  logic [31:0]        rt_safe;
  logic [31:0]        q_u, r_u;
  logic [31:0]        rs_mag, rt_mag;
  logic [31:0]        q_mag, r_mag;
  logic [31:0]        q_s, r_s;

  // Full-width products; the low 64 bits of a sign-extended multiply are the exact signed product.
  always_comb begin
    rs_sx  = {{32{rs_val[31]}}, rs_val};
    rt_sx  = {{32{rt_val[31]}}, rt_val};
    prod_s = rs_sx * rt_sx;
    prod_u = {32'd0, rs_val} * {32'd0, rt_val};
  end

  // Divide on magnitudes, then restore signs; a zero divisor is replaced so nothing goes X.
  always_comb begin
    rt_zero = (rt_val == 32'd0);
    rt_safe = rt_zero ? 32'd1 : rt_val;
    q_u     = rs_val / rt_safe;
    r_u     = rs_val % rt_safe;
    rs_mag  = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    rt_mag  = rt_zero ? 32'd1 : (rt_val[31] ? (~rt_val + 32'd1) : rt_val);
    q_mag   = rs_mag / rt_mag;
    r_mag   = rs_mag % rt_mag;
    q_s     = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s     = rs_val[31] ? (~r_mag + 32'd1) : r_mag;
  end

  assign accept = start && !Req && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (md_op)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              div0_d  = 1'b0;
              cnt_d   = MULT_CNT;
              state_d = ST_MUL;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              div0_d  = 1'b0;
              cnt_d   = MULT_CNT;
              state_d = ST_MUL;
            end
            OP_DIV: begin
              pend_lo_d = q_s;
              pend_hi_d = r_s;
              div0_d    = rt_zero;
              cnt_d     = DIV_CNT;
              state_d   = ST_DIV;
            end
            OP_DIVU: begin
              pend_lo_d = q_u;
              pend_hi_d = r_u;
              div0_d    = rt_zero;
              cnt_d     = DIV_CNT;
              state_d   = ST_DIV;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      // In-flight ops belong to committed instructions, so Req does not cancel them.
      ST_MUL, ST_DIV: begin
        if (cnt_q == 4'd1) begin
          if (!div0_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      div0_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy          = busy_q;
  assign hi            = hi_q;
  assign lo            = lo_q;
  assign multdiv_res_E = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: latency, arithmetic, flush, reset and read-mux behaviour.
module tb_multdiv_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] multdiv_res_E;

  int checks = 0;
  int failures = 0;

  multdiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Req(Req), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .rd_sel(rd_sel), .busy(busy),
    .hi(hi), .lo(lo), .multdiv_res_E(multdiv_res_E)
  );

  always #5 clk = ~clk;

  // The hazard unit never presents a new md op while one is in flight.
  always @(negedge clk) begin
    if (reset === 1'b1 && start === 1'b1)
      assert (busy !== 1'b1) else $error("start presented while busy");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b; Req = rq;
    tick();
    start = 1'b0; md_op = 3'd0; Req = 1'b0;
  endtask

  // Counts busy cycles after an accept edge, bounded so a stuck busy cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
  endtask

  task automatic test_mult();
    int n;
    issue(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL mult_hi_early got=%h exp=00000000", hi); end
    count_busy(n);
    checks++; if (n != 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin failures++; $display("FAIL mult_lo got=%h exp=fffffff1", lo); end
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    count_busy(n);
    checks++; if (n != 5) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
    checks++; if (hi !== 32'h0000_0001) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", hi); end
    checks++; if (lo !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
  endtask

  task automatic test_div();
    int n;
    issue(3'd4, 32'd17, 32'd5, 1'b0);
    count_busy(n);
    checks++; if (n != 10) begin failures++; $display("FAIL divu_busy_cycles got=%0d exp=10", n); end
    checks++; if (lo !== 32'd3 || hi !== 32'd2) begin failures++; $display("FAIL divu_result got=%h/%h exp=00000002/00000003", hi, lo); end
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    count_busy(n);
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg_dividend got=%h/%h exp=ffffffff/fffffffd", hi, lo); end
    issue(3'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
    count_busy(n);
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin failures++; $display("FAIL div_neg_divisor got=%h/%h exp=00000001/fffffffd", hi, lo); end
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    count_busy(n);
    checks++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin failures++; $display("FAIL div_overflow got=%h/%h exp=00000000/80000000", hi, lo); end
  endtask

  task automatic test_div0();
    int n;
    issue(3'd5, 32'h11, 32'd0, 1'b0);
    checks++; if (hi !== 32'h11 || busy !== 1'b0) begin failures++; $display("FAIL mthi got=%h busy=%b exp=00000011 busy=0", hi, busy); end
    issue(3'd6, 32'h22, 32'd0, 1'b0);
    checks++; if (lo !== 32'h22 || busy !== 1'b0) begin failures++; $display("FAIL mtlo got=%h busy=%b exp=00000022 busy=0", lo, busy); end
    issue(3'd3, 32'd99, 32'd0, 1'b0);
    count_busy(n);
    checks++; if (n != 10) begin failures++; $display("FAIL div0_busy_cycles got=%0d exp=10", n); end
    checks++; if (hi !== 32'h11 || lo !== 32'h22) begin failures++; $display("FAIL div0_hilo got=%h/%h exp=00000011/00000022", hi, lo); end
  endtask

  task automatic test_req();
    int n;
    issue(3'd1, 32'd6, 32'd7, 1'b1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL req_block_busy got=%b exp=0", busy); end
    tick(); tick();
    checks++; if (hi !== 32'h11 || lo !== 32'h22) begin failures++; $display("FAIL req_block_hilo got=%h/%h exp=00000011/00000022", hi, lo); end
    issue(3'd5, 32'hDEAD, 32'd0, 1'b1);
    checks++; if (hi !== 32'h11) begin failures++; $display("FAIL req_block_mthi got=%h exp=00000011", hi); end
    issue(3'd1, 32'd6, 32'd7, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      Req = (n == 2);
      tick();
    end
    Req = 1'b0;
    checks++; if (n != 5) begin failures++; $display("FAIL req_mid_busy_cycles got=%0d exp=5", n); end
    checks++; if (hi !== 32'd0 || lo !== 32'd42) begin failures++; $display("FAIL req_mid_result got=%h/%h exp=00000000/0000002a", hi, lo); end
  endtask

  task automatic test_noop();
    issue(3'd0, 32'd5, 32'd5, 1'b0);
    checks++; if (busy !== 1'b0 || lo !== 32'd42) begin failures++; $display("FAIL noop0 busy=%b lo=%h exp=0/0000002a", busy, lo); end
    issue(3'd7, 32'd5, 32'd5, 1'b0);
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd42) begin failures++; $display("FAIL noop7 busy=%b hi=%h lo=%h exp=0/00000000/0000002a", busy, hi, lo); end
  endtask

  task automatic test_rd_sel();
    issue(3'd5, 32'hAAAA_0001, 32'd0, 1'b0);
    issue(3'd6, 32'h5555_0002, 32'd0, 1'b0);
    rd_sel = 1'b1; #1;
    checks++; if (multdiv_res_E !== 32'hAAAA_0001) begin failures++; $display("FAIL rdsel_hi got=%h exp=aaaa0001", multdiv_res_E); end
    rd_sel = 1'b0; #1;
    checks++; if (multdiv_res_E !== 32'h5555_0002) begin failures++; $display("FAIL rdsel_lo got=%h exp=55550002", multdiv_res_E); end
    rd_sel = 1'b1; #1;
    checks++; if (multdiv_res_E !== 32'hAAAA_0001) begin failures++; $display("FAIL rdsel_hi_again got=%h exp=aaaa0001", multdiv_res_E); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(3'd2, 32'd1000, 32'd1000, 1'b0);
    count_busy(n);
    issue(3'd4, 32'd100, 32'd7, 1'b0);
    count_busy(n);
    checks++; if (n != 10 || lo !== 32'd14 || hi !== 32'd2) begin failures++; $display("FAIL b2b_div n=%0d got=%h/%h exp=10 00000002/0000000e", n, hi, lo); end
    issue(3'd5, 32'h77, 32'd0, 1'b0);
    checks++; if (hi !== 32'h77 || lo !== 32'd14) begin failures++; $display("FAIL b2b_mthi got=%h/%h exp=00000077/0000000e", hi, lo); end
  endtask

  task automatic test_reset_mid();
    logic bad;
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL reset_mid busy=%b hi=%h lo=%h exp=0/00000000/00000000", busy, hi, lo); end
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL reset_mid_later got=%b exp=0 (hi=%h lo=%h)", bad, hi, lo); end
  endtask

  initial begin
    reset = 1'b0; Req = 1'b0; start = 1'b0; md_op = 3'd0;
    rs_val = 32'd0; rt_val = 32'd0; rd_sel = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_req();
    test_noop();
    test_rd_sel();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
